alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Multi-cycle multiply/divide sequencer that time-shares the existing 32-bit ALU to execute MIPS `multu` and `divu` iteratively, producing HI/LO results. It sits beside the single-cycle datapath. While the datapath issues no ALU operation, the ALU operand and control muxes select this block's `alu_a`/`alu_b`/`alu_control`, and its `alu_result` feeds back here. A start/busy/done handshake lets the control unit stall on `mfhi`/`mflo` until results are valid.

## Interface
- Parameters: none (width fixed at 32 to match the ALU).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a new operation; accepted only when `busy`=0.
- `op` in 1: 0 = multu, 1 = divu; sampled with `start`.
- `src_a` in 32: multiplicand / dividend; sampled with `start`.
- `src_b` in 32: multiplier / divisor; sampled with `start`.
- `busy` out 1: high while iterating.
- `done` out 1: one-cycle pulse when `hi`/`lo` become valid.
- `hi` out 32: product[63:32] / remainder.
- `lo` out 32: product[31:0] / quotient.
- `alu_a` out 32: operand A to the shared ALU.
- `alu_b` out 32: operand B to the shared ALU.
- `alu_control` out 4: ALU op code (0010 add, 0110 sub, 0111 unsigned set-less-than).
- `alu_result` in 32: combinational ALU result for the current `alu_a`/`alu_b`/`alu_control`.

## Operation
- FSM states: IDLE, MUL, DIV_CMP, DIV_SUB, DONE.
- Internal state: 6-bit iteration counter, 32-bit operand register `opnd`, 32-bit `shifted`, 1-bit `rem_msb`.
- IDLE/DONE: `alu_a`=`alu_b`=0, `alu_control`=0010. `start`=1 is accepted in either state.
- multu accept: `hi`←0, `lo`←`src_b`, `opnd`←`src_a`, counter←0, go to MUL.
- MUL, each of 32 cycles:
  - ALU drive: `alu_a`=`hi`, `alu_b`=`lo[0]` ? `opnd` : 0, `alu_control`=0010.
  - Carry: `carry` = (`alu_result` < `hi`), unsigned.
  - Update: {`hi`,`lo`} ← {`carry`, `alu_result`, `lo[31:1]`}.
  - After the 32nd iteration, go to DONE.
- divu accept with `src_b`≠0: `hi`←0, `lo`←`src_a`, `opnd`←`src_b`, counter←0, go to DIV_CMP.
- divu accept with `src_b`=0: `hi`←`src_a`, `lo`←32'hFFFFFFFF, go directly to DONE. No ALU use.
- DIV_CMP (restoring division, one bit per CMP+SUB pair):
  - `shifted` = {`hi[30:0]`, `lo[31]`}; register `shifted` and `rem_msb`←`hi[31]`.
  - ALU drive: `alu_a`=`shifted`, `alu_b`=`opnd`, `alu_control`=0111.
  - Register `ge` = `rem_msb` | (`alu_result`==0).
- DIV_SUB:
  - ALU drive: `alu_a`=`shifted` (registered), `alu_b`=`opnd`, `alu_control`=0110.
  - If `ge`: `hi`←`alu_result`, `lo`←{`lo[30:0]`,1}.
  - Else: `hi`←`shifted`, `lo`←{`lo[30:0]`,0}.
  - After 32 pairs, go to DONE; otherwise return to DIV_CMP.
- All arithmetic is unsigned modulo 2^32. When `rem_msb`=1 the true shifted remainder is ≥2^32 > divisor, so the subtract is forced and its wrapped 32-bit result is exact.
- DONE: `done`=1 for exactly one cycle, then IDLE. `hi`/`lo` hold until the next accepted `start` or `reset`.

## Timing
- Reset value of every output: `busy`=0, `done`=0, `hi`=0, `lo`=0, `alu_a`=0, `alu_b`=0, `alu_control`=0010. State returns to IDLE.
- Cycle 0 is the edge that samples `start`=1.
- multu: `busy`=1 in cycles 1–32; `done`=1 and results valid in cycle 33.
- divu: `busy`=1 in cycles 1–64; `done`=1 in cycle 65.
- divu by zero: `done`=1 in cycle 1; `busy` never asserts.
- `start` while `busy`=1 is ignored with no side effects.
- `start` in a DONE cycle is accepted; `done` still pulses in that cycle.
- `reset` has priority over everything. Reset mid-operation aborts the operation, discards partial results and produces no `done`.
- `busy` and `done` are registered (FSM-decoded). `alu_a`/`alu_b`/`alu_control` are functions of registered state only, so there is no combinational path from `alu_result`.

## Test plan
- multu 7×6: `hi`=0, `lo`=42; `done` at cycle 33, `busy` high for exactly 32 cycles.
- multu 0xFFFFFFFF×0xFFFFFFFF: `hi`=0xFFFFFFFE, `lo`=0x00000001 (exercises the carry path).
- divu 100÷7: `lo`=14, `hi`=2, `done` at cycle 65. divu 0xFFFFFFFF÷1: `lo`=0xFFFFFFFF, `hi`=0 (exercises `rem_msb`). divu 0x80000000÷0xFFFFFFFF: `lo`=0, `hi`=0x80000000.
- divu 1234÷0: `hi`=1234, `lo`=0xFFFFFFFF, `done` at cycle 1, `busy` stays 0.
- multu 3×5 with `start` pulsed again at cycle 10 using different operands: second request ignored, result 15. Then `start` in the DONE cycle is accepted and its `done` arrives 33 cycles later.
- `reset` at cycle 20 of a divu: next cycle all outputs at reset values, no `done` pulse. A fresh multu 2×2 afterwards gives `lo`=4.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Iterative multu/divu sequencer that borrows the shared 32-bit ALU while the
// datapath leaves it idle; results appear on hi/lo with a one-cycle done pulse.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result
);
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_CMP,
        S_DIV_SUB,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opnd;
    logic [31:0] r_shifted;
    logic        r_rem_msb;
    logic        r_cmp_ge;
    logic [5:0]  r_cnt;

    logic        w_accept;
    logic        w_carry;
    logic        w_take;
    logic [31:0] w_shifted;

    assign w_accept  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_carry   = (alu_result < r_hi);
    assign w_shifted = {r_hi[30:0], r_lo[31]};
    // A set remainder MSB means the shifted remainder is >= 2^32, always above the divisor.
    assign w_take    = r_rem_msb | r_cmp_ge;

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state == S_MUL) || (r_state == S_DIV_CMP) || (r_state == S_DIV_SUB);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        alu_a        = 32'd0;
        alu_b        = 32'd0;
        alu_control  = ALU_ADD;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (!op) begin
                        w_state_next = S_MUL;
                    end else if (src_b == 32'd0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_DIV_CMP;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_MUL: begin
                alu_a = r_hi;
                alu_b = r_lo[0] ? r_opnd : 32'd0;
                if (r_cnt == 6'd31) begin
                    w_state_next = S_DONE;
                end
            end
            S_DIV_CMP: begin
                alu_a        = w_shifted;
                alu_b        = r_opnd;
                alu_control  = ALU_SLTU;
                w_state_next = S_DIV_SUB;
            end
            S_DIV_SUB: begin
                alu_a        = r_shifted;
                alu_b        = r_opnd;
                alu_control  = ALU_SUB;
                w_state_next = (r_cnt == 6'd31) ? S_DONE : S_DIV_CMP;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_opnd    <= 32'd0;
            r_shifted <= 32'd0;
            r_rem_msb <= 1'b0;
            r_cmp_ge  <= 1'b0;
            r_cnt     <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_cnt <= 6'd0;
                        if (!op) begin
                            r_hi   <= 32'd0;
                            r_lo   <= src_b;
                            r_opnd <= src_a;
                        end else if (src_b != 32'd0) begin
                            r_hi   <= 32'd0;
                            r_lo   <= src_a;
                            r_opnd <= src_b;
                        end else begin
                            r_hi <= src_a;
                            r_lo <= 32'hFFFF_FFFF;
                        end
                    end
                end
                S_MUL: begin
                    {r_hi, r_lo} <= {w_carry, alu_result, r_lo[31:1]};
                    r_cnt        <= r_cnt + 6'd1;
                end
                S_DIV_CMP: begin
                    r_shifted <= w_shifted;
                    r_rem_msb <= r_hi[31];
                    r_cmp_ge  <= (alu_result == 32'd0);
                end
                S_DIV_SUB: begin
                    r_hi  <= w_take ? alu_result : r_shifted;
                    r_lo  <= {r_lo[30:0], w_take};
                    r_cnt <= r_cnt + 6'd1;
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a behavioural shared ALU closes the loop and
// hand-computed HI/LO values, done latency and busy length are compared.
module tb_alu_seq_ctrl;
    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the datapath ALU
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {31'd0, (alu_a < alu_b)};
            default: alu_result = 32'd0;
        endcase
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of cycle 1.
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts cycles from cycle 1 until done; optionally re-pulses start at cycle poke.
    task automatic wait_done(input int poke, output int cyc, output int busy_cnt);
        cyc      = 1;
        busy_cnt = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_cnt++;
            if (cyc == poke) begin
                start = 1'b1;
                op    = 1'b1;
                src_a = 32'd9;
                src_b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_cyc, input int exp_busy, input string tag);
        int cyc;
        int bc;
        @(negedge clk);
        issue(o, a, b);
        wait_done(0, cyc, bc);
        check_val({tag, "_done_cyc"}, 64'(cyc), 64'(exp_cyc));
        check_val({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
        check_val({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check_val({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int cyc;
        int bc;
        int pulses;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        check_val("rst_alu_a", 64'(alu_a), 64'd0);
        check_val("rst_alu_b", 64'(alu_b), 64'd0);
        check_val("rst_alu_ctl", 64'(alu_control), 64'h2);
        reset = 1'b0;

        run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 33, 32, "mul_7x6");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 32, "mul_max");
        run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 65, 64, "div_100_7");
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 65, 64, "div_max_1");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 65, 64, "div_msb");
        run_op(1'b1, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, 1, 0, "div_by0");

        @(negedge clk);
        check_val("hold_hi", 64'(hi), 64'd1234);
        check_val("hold_lo", 64'(lo), 64'hFFFF_FFFF);
        check_val("hold_done", 64'(done), 64'd0);

        // multu 3x5, second start at cycle 10 must be ignored
        @(negedge clk);
        issue(1'b0, 32'd3, 32'd5);
        check_val("mul_alu_a", 64'(alu_a), 64'd0);
        check_val("mul_alu_b", 64'(alu_b), 64'd3);
        check_val("mul_alu_ctl", 64'(alu_control), 64'h2);
        wait_done(10, cyc, bc);
        check_val("busy_start_cyc", 64'(cyc), 64'd33);
        check_val("busy_start_busy", 64'(bc), 64'd32);
        check_val("busy_start_hi", 64'(hi), 64'd0);
        check_val("busy_start_lo", 64'(lo), 64'd15);

        // start presented during the DONE cycle
        issue(1'b0, 32'd4, 32'd5);
        wait_done(0, cyc, bc);
        check_val("done_start_cyc", 64'(cyc), 64'd33);
        check_val("done_start_busy", 64'(bc), 64'd32);
        check_val("done_start_lo", 64'(lo), 64'd20);

        // reset in cycle 20 of a divu
        @(negedge clk);
        issue(1'b1, 32'd100, 32'd7);
        check_val("div_cmp_alu_a", 64'(alu_a), 64'd0);
        check_val("div_cmp_alu_b", 64'(alu_b), 64'd7);
        check_val("div_cmp_alu_ctl", 64'(alu_control), 64'h7);
        @(negedge clk);
        check_val("div_sub_alu_ctl", 64'(alu_control), 64'h6);
        repeat (18) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_done", 64'(done), 64'd0);
        check_val("mid_rst_hi", 64'(hi), 64'd0);
        check_val("mid_rst_lo", 64'(lo), 64'd0);
        check_val("mid_rst_alu_a", 64'(alu_a), 64'd0);
        check_val("mid_rst_alu_b", 64'(alu_b), 64'd0);
        check_val("mid_rst_alu_ctl", 64'(alu_control), 64'h2);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check_val("mid_rst_no_done", 64'(pulses), 64'd0);

        run_op(1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 33, 32, "mul_2x2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
